// File: rtl/mesh_injector.sv
// mesh_injector: local flit injection queue for a 2D-mesh router input stage.
// Incoming channel flits pass through one register stage with their routing
// direction attached. Locally injected flits are queued, then either ejected
// (destined here) or slotted into an idle channel chosen round-robin.
// Optional feature macro: MESH_INJECTOR_STARVE_EN (head-of-queue starvation flag).
module mesh_injector #(
  parameter int COORD_W    = 3,
  parameter int NODE_X     = 4,
  parameter int NODE_Y     = 4,
  parameter int DEPTH      = 4,
  parameter int PAYLOAD_W  = 8,
  parameter int STARVE_LIM = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inj_valid,
  output logic                       inj_ready,
  input  logic [2*COORD_W-1:0]       inj_dst,
  input  logic [PAYLOAD_W-1:0]       inj_data,
  input  logic [3:0]                 in_valid,
  input  logic [4*2*COORD_W-1:0]     in_dst,
  input  logic [4*PAYLOAD_W-1:0]     in_data,
  output logic [3:0]                 out_valid,
  output logic [4*2*COORD_W-1:0]     out_dst,
  output logic [4*PAYLOAD_W-1:0]     out_data,
  output logic [4*5-1:0]             out_dir,
  output logic                       ej_valid,
  output logic [PAYLOAD_W-1:0]       ej_data,
  output logic                       inj_starve
);

  localparam int AW = 2 * COORD_W;
  localparam int PW = $clog2(DEPTH);
  localparam int EW = AW + PAYLOAD_W;
  localparam logic [COORD_W-1:0] NX = COORD_W'(NODE_X);
  localparam logic [COORD_W-1:0] NY = COORD_W'(NODE_Y);
  localparam logic [AW-1:0] LOCAL_ADDR = {NY, NX};
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  // Dimension-order routing: resolve column first, then row, else local.
  function automatic logic [4:0] route_dir(input logic [AW-1:0] dst);
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    row = dst[AW-1:COORD_W];
    col = dst[COORD_W-1:0];
    if (col > NX)      route_dir = 5'b00001;
    else if (col < NX) route_dir = 5'b00010;
    else if (row > NY) route_dir = 5'b00100;
    else if (row < NY) route_dir = 5'b01000;
    else               route_dir = 5'b10000;
  endfunction

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [1:0]       rr_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             eject;
  logic             inject;
  logic [1:0]       sel;
  logic [1:0]       idx;
  logic [EW-1:0]    head;
  logic [AW-1:0]    head_dst;
  logic [PAYLOAD_W-1:0] head_data;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign inj_ready = rst_n & ~full;
  assign push      = inj_valid & inj_ready;
  assign head      = mem[rd_ptr];
  assign head_dst  = head[EW-1:PAYLOAD_W];
  assign head_data = head[PAYLOAD_W-1:0];

  // Head disposition: eject if addressed here, else first idle channel from rr_ptr.
  always_comb begin
    pop    = 1'b0;
    eject  = 1'b0;
    inject = 1'b0;
    sel    = 2'd0;
    idx    = 2'd0;
    if (!empty) begin
      if (head_dst == LOCAL_ADDR) begin
        pop   = 1'b1;
        eject = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          idx = rr_ptr + 2'(k);
          if (!inject && !in_valid[idx]) begin
            inject = 1'b1;
            sel    = idx;
          end else begin
            inject = inject;
          end
        end
        pop = inject;
      end
    end else begin
      pop = 1'b0;
    end
  end

  // Queue storage; contents are don't-care while pointers say empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {inj_dst, inj_data};
  end

  // Queue pointers and occupancy; simultaneous push/pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage: channel passthrough has priority, injected head fills an idle slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 4'b0000;
      out_dst   <= '0;
      out_data  <= '0;
      out_dir   <= '0;
      ej_valid  <= 1'b0;
      ej_data   <= '0;
      rr_ptr    <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i]) begin
          out_valid[i]                     <= 1'b1;
          out_dst[i*AW +: AW]              <= in_dst[i*AW +: AW];
          out_data[i*PAYLOAD_W +: PAYLOAD_W] <= in_data[i*PAYLOAD_W +: PAYLOAD_W];
          out_dir[i*5 +: 5]                <= route_dir(in_dst[i*AW +: AW]);
        end else if (inject && (sel == 2'(i))) begin
          out_valid[i]                     <= 1'b1;
          out_dst[i*AW +: AW]              <= head_dst;
          out_data[i*PAYLOAD_W +: PAYLOAD_W] <= head_data;
          out_dir[i*5 +: 5]                <= route_dir(head_dst);
        end else begin
          out_valid[i]                     <= 1'b0;
          out_dst[i*AW +: AW]              <= '0;
          out_data[i*PAYLOAD_W +: PAYLOAD_W] <= '0;
          out_dir[i*5 +: 5]                <= 5'b00000;
        end
      end
      ej_valid <= eject;
      ej_data  <= eject ? head_data : '0;
      rr_ptr   <= inject ? (sel + 2'd1) : rr_ptr;
    end
  end

`ifdef MESH_INJECTOR_STARVE_EN
  logic [7:0] starve_cnt;
  logic [7:0] starve_cnt_next;

  // Consecutive non-empty cycles without a pop, saturating at 255.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (empty || pop)               starve_cnt_next = 8'd0;
    else if (starve_cnt != 8'hFF)   starve_cnt_next = starve_cnt + 8'd1;
    else                            starve_cnt_next = starve_cnt;
  end

  // Counter and flag registers; flag tracks the updated count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 8'd0;
      inj_starve <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_next;
      inj_starve <= (starve_cnt_next >= 8'(STARVE_LIM));
    end
  end
`else
  assign inj_starve = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_injector.sv
// Directed self-checking bench for mesh_injector (default parameters:
// node (x=4,y=4), 3-bit coordinates, 4-deep queue, 8-bit payload).
// Honors MESH_INJECTOR_STARVE_EN for the starvation scenario.
module tb_mesh_injector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inj_valid;
  logic        inj_ready;
  logic [5:0]  inj_dst;
  logic [7:0]  inj_data;
  logic [3:0]  in_valid;
  logic [23:0] in_dst;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [23:0] out_dst;
  logic [31:0] out_data;
  logic [19:0] out_dir;
  logic        ej_valid;
  logic [7:0]  ej_data;
  logic        inj_starve;

  int checks = 0;
  int errors = 0;

  mesh_injector dut (
    .clk(clk), .rst_n(rst_n),
    .inj_valid(inj_valid), .inj_ready(inj_ready),
    .inj_dst(inj_dst), .inj_data(inj_data),
    .in_valid(in_valid), .in_dst(in_dst), .in_data(in_data),
    .out_valid(out_valid), .out_dst(out_dst), .out_data(out_data),
    .out_dir(out_dir), .ej_valid(ej_valid), .ej_data(ej_data),
    .inj_starve(inj_starve)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inj_valid = 1'b0; inj_dst = 6'd0; inj_data = 8'd0;
    in_valid = 4'b0000; in_dst = 24'd0; in_data = 32'd0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inj_valid = 1'b0; inj_dst = 6'd0; inj_data = 8'd0;
    in_valid = 4'b0000; in_dst = 24'd0; in_data = 32'd0;
    #2;
    checks++; if (inj_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", inj_ready); end
    tick();
    checks++; if (out_valid !== 4'b0000 || ej_valid !== 1'b0 || inj_starve !== 1'b0) begin
      errors++; $display("FAIL rst_outs: out_valid=%b ej_valid=%b starve=%b want 0", out_valid, ej_valid, inj_starve); end
    rst_n = 1'b1;
    #1;
    checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", inj_ready); end
  endtask

  // East-bound flit, then confirm the round-robin pointer moved to channel 1.
  task automatic test_east();
    do_reset();
    inj_valid = 1'b1; inj_dst = 6'b100_110; inj_data = 8'hA5;
    tick();
    inj_valid = 1'b0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL east_no_bypass: got %b want 0000", out_valid); end
    tick();
    checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL east_valid: got %b want 0001", out_valid); end
    checks++; if (out_dir[4:0] !== 5'b00001) begin errors++; $display("FAIL east_dir: got %b want 00001", out_dir[4:0]); end
    checks++; if (out_dst[5:0] !== 6'b100_110 || out_data[7:0] !== 8'hA5) begin
      errors++; $display("FAIL east_flit: got dst=%b data=%h want 100110/a5", out_dst[5:0], out_data[7:0]); end
    inj_valid = 1'b1; inj_dst = 6'b111_100; inj_data = 8'h5A;
    tick();
    inj_valid = 1'b0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL east_idle: got %b want 0000", out_valid); end
    tick();
    checks++; if (out_valid !== 4'b0010 || out_dir[9:5] !== 5'b00100 || out_data[15:8] !== 8'h5A) begin
      errors++; $display("FAIL rr_next: got valid=%b dir1=%b data1=%h want 0010/00100/5a", out_valid, out_dir[9:5], out_data[15:8]); end
  endtask

  task automatic test_local();
    do_reset();
    in_valid = 4'b1111;
    in_dst  = {6'b100_100, 6'b110_100, 6'b011_001, 6'b100_101};
    in_data = 32'hD4C3B2A1;
    inj_valid = 1'b1; inj_dst = 6'b100_100; inj_data = 8'h3C;
    tick();
    inj_valid = 1'b0;
    checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL local_no_bypass: got %b want 0", ej_valid); end
    tick();
    checks++; if (ej_valid !== 1'b1 || ej_data !== 8'h3C) begin
      errors++; $display("FAIL local_eject: got v=%b d=%h want 1/3c", ej_valid, ej_data); end
    checks++; if (out_valid !== 4'b1111 || out_data !== 32'hD4C3B2A1 || out_dst !== in_dst) begin
      errors++; $display("FAIL local_pass: got v=%b d=%h want 1111/d4c3b2a1", out_valid, out_data); end
    checks++; if (out_dir !== 20'b10000_00100_00010_00001) begin
      errors++; $display("FAIL pass_dirs: got %b want 10000_00100_00010_00001", out_dir); end
    tick();
    checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL local_once: got %b want 0", ej_valid); end
    in_valid = 4'b0000;
  endtask

  // Three south-bound flits from reset fill channels 0,1,2; then wrap and skip busy.
  task automatic test_south();
    do_reset();
    inj_valid = 1'b1; inj_dst = 6'b000_100; inj_data = 8'h11;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL south_first: got %b want 0000", out_valid); end
    inj_data = 8'h22;
    tick();
    checks++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h11 || out_dir[4:0] !== 5'b01000) begin
      errors++; $display("FAIL south_ch0: got v=%b d=%h dir=%b want 0001/11/01000", out_valid, out_data[7:0], out_dir[4:0]); end
    inj_data = 8'h33;
    tick();
    inj_valid = 1'b0;
    checks++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h22 || out_dir[9:5] !== 5'b01000) begin
      errors++; $display("FAIL south_ch1: got v=%b d=%h dir=%b want 0010/22/01000", out_valid, out_data[15:8], out_dir[9:5]); end
    tick();
    checks++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h33 || out_dir[14:10] !== 5'b01000) begin
      errors++; $display("FAIL south_ch2: got v=%b d=%h dir=%b want 0100/33/01000", out_valid, out_data[23:16], out_dir[14:10]); end
    inj_valid = 1'b1; inj_dst = 6'b010_000; inj_data = 8'h44;
    tick();
    inj_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b1000 || out_dir[19:15] !== 5'b00010 || out_data[31:24] !== 8'h44) begin
      errors++; $display("FAIL rr_wrap_ch3: got v=%b dir=%b d=%h want 1000/00010/44", out_valid, out_dir[19:15], out_data[31:24]); end
    inj_valid = 1'b1; inj_dst = 6'b010_000; inj_data = 8'h55;
    tick();
    inj_valid = 1'b0;
    in_valid = 4'b0001; in_dst = {18'd0, 6'b100_111}; in_data = {24'd0, 8'hEE};
    tick();
    checks++; if (out_valid !== 4'b0011 || out_data[15:0] !== 16'h55EE || out_dir[9:0] !== 10'b00010_00001) begin
      errors++; $display("FAIL rr_skip_busy: got v=%b d=%h dir=%b want 0011/55ee/0001000001", out_valid, out_data[15:0], out_dir[9:0]); end
    in_valid = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    in_valid = 4'b1111; in_dst = 24'd0; in_data = 32'h01020304;
    inj_valid = 1'b1; inj_dst = 6'b000_000;
    for (int k = 0; k < 4; k++) begin
      d = 8'h80 + 8'(k);
      inj_data = d;
      tick();
      checks++; if (inj_ready !== (k < 3)) begin
        errors++; $display("FAIL fill_ready%0d: got %b want %b", k, inj_ready, (k < 3)); end
    end
    inj_data = 8'h84;
    tick();
    checks++; if (inj_ready !== 1'b0 || out_valid !== 4'b1111 || out_data !== 32'h01020304) begin
      errors++; $display("FAIL full_hold: got rdy=%b v=%b d=%h want 0/1111/01020304", inj_ready, out_valid, out_data); end
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h80 || inj_ready !== 1'b1) begin
      errors++; $display("FAIL drain0: got v=%b d=%h rdy=%b want 0001/80/1", out_valid, out_data[7:0], inj_ready); end
    tick();
    inj_valid = 1'b0;
    checks++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h81 || out_dir[9:5] !== 5'b00010) begin
      errors++; $display("FAIL drain1: got v=%b d=%h dir=%b want 0010/81/00010", out_valid, out_data[15:8], out_dir[9:5]); end
    tick();
    checks++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h82) begin
      errors++; $display("FAIL drain2: got v=%b d=%h want 0100/82", out_valid, out_data[23:16]); end
    tick();
    checks++; if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h83) begin
      errors++; $display("FAIL drain3: got v=%b d=%h want 1000/83", out_valid, out_data[31:24]); end
    tick();
    checks++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h84) begin
      errors++; $display("FAIL drain4: got v=%b d=%h want 0001/84", out_valid, out_data[7:0]); end
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL drain_empty: got %b want 0000", out_valid); end
  endtask

  task automatic test_starve();
    logic starve_en;
`ifdef MESH_INJECTOR_STARVE_EN
    starve_en = 1'b1;
`else
    starve_en = 1'b0;
`endif
    do_reset();
    in_valid = 4'b1111; in_dst = 24'd0; in_data = 32'd0;
    inj_valid = 1'b1; inj_dst = 6'b001_001; inj_data = 8'h77;
    tick();
    inj_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++; if (inj_starve !== 1'b0) begin errors++; $display("FAIL starve_early%0d: got %b want 0", k, inj_starve); end
    end
    tick();
    checks++; if (inj_starve !== starve_en) begin errors++; $display("FAIL starve_set: got %b want %b", inj_starve, starve_en); end
    in_valid = 4'b0000;
    tick();
    checks++; if (inj_starve !== 1'b0 || out_valid !== 4'b0001 || out_data[7:0] !== 8'h77) begin
      errors++; $display("FAIL starve_clear: got st=%b v=%b d=%h want 0/0001/77", inj_starve, out_valid, out_data[7:0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 4'b1111; in_dst = {4{6'b100_110}}; in_data = 32'hCAFEF00D;
    inj_valid = 1'b1; inj_dst = 6'b000_001;
    for (int k = 0; k < 3; k++) begin
      inj_data = 8'h90 + 8'(k);
      tick();
    end
    inj_valid = 1'b0;
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL mid_busy: got %b want 1111", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000 || out_dst !== 24'd0 || out_data !== 32'd0 || out_dir !== 20'd0 ||
                  ej_valid !== 1'b0 || ej_data !== 8'd0 || inj_ready !== 1'b0 || inj_starve !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear: v=%b d=%h dir=%h ej=%b rdy=%b want zeros", out_valid, out_data, out_dir, ej_valid, inj_ready); end
    in_valid = 4'b0000;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", inj_ready); end
    tick();
    tick();
    checks++; if (out_valid !== 4'b0000 || ej_valid !== 1'b0) begin
      errors++; $display("FAIL mid_stale: got v=%b ej=%b want 0000/0", out_valid, ej_valid); end
  endtask

  initial begin
    test_reset();
    test_east();
    test_local();
    test_south();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_injector.md
MESH_INJECTOR -- requirements
Module: mesh_injector

Interface
REQ-001 Parameter COORD_W, default 3, width of one mesh coordinate; address = {row, col}, 2*COORD_W bits.
REQ-002 Parameter NODE_X, default 4, column of this node.
REQ-003 Parameter NODE_Y, default 4, row of this node.
REQ-004 Parameter DEPTH, default 4, local injection FIFO entries, power of two, >= 2.
REQ-005 Parameter PAYLOAD_W, default 8, flit payload width.
REQ-006 Parameter STARVE_LIM, default 8, starvation threshold in cycles, 1..255.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 inj_valid / inj_ready  in / out  1 / 1  local injection handshake; transfer when both high at a clk edge.
REQ-010 inj_dst / inj_data  in  2*COORD_W / PAYLOAD_W  injected flit destination and payload.
REQ-011 in_valid  in  4  per-channel occupancy; index 0 east, 1 west, 2 north, 3 south.
REQ-012 in_dst / in_data  in  4*2*COORD_W / 4*PAYLOAD_W  per-channel destination and payload, channel i in slice i.
REQ-013 out_valid / out_dst / out_data  out  4 / 4*2*COORD_W / 4*PAYLOAD_W  registered per-channel flits to the routing stage.
REQ-014 out_dir  out  4*5  per-channel one-hot direction: 00001 E, 00010 W, 00100 N, 01000 S, 10000 LOCAL.
REQ-015 ej_valid / ej_data  out  1 / PAYLOAD_W  registered local-eject flit.
REQ-016 inj_starve  out  1  head-of-queue starvation flag.

Function
REQ-017 inj_ready SHALL equal (FIFO not full) and SHALL be 0 while rst_n is low.
REQ-018 An accepted flit SHALL be written to the FIFO tail; no bypass: push-to-output latency is at least 2 cycles.
REQ-019 Channel i with in_valid[i]=1 SHALL appear on out slice i, unchanged, one cycle later, out_valid[i]=1.
REQ-020 Direction per output flit: col > NODE_X -> E; col < NODE_X -> W; col = NODE_X: row > NODE_Y -> N, row < NODE_Y -> S, equal -> LOCAL; unsigned compare; out_dir=0 when out_valid[i]=0.
REQ-021 Per cycle at most one FIFO pop.
REQ-022 If the head destination equals {NODE_Y, NODE_X}, head SHALL pop to ej_valid/ej_data next cycle regardless of channel occupancy.
REQ-023 Else, the head SHALL be placed in the first idle channel (in_valid[i]=0) searched from rr_ptr upward modulo 4; rr_ptr then SHALL become (chosen+1) mod 4.
REQ-024 If all four channels are busy, the head SHALL stay; rr_ptr unchanged.
REQ-025 Push and pop in the same cycle SHALL both occur; occupancy unchanged; FIFO pointers wrap modulo DEPTH.
REQ-026 Push when full is impossible (inj_ready=0); pop when empty SHALL not occur.

Reset
REQ-027 rst_n low SHALL immediately clear: FIFO (empty), rr_ptr=0, starve counter=0, out_valid=0, out_dst=0, out_data=0, out_dir=0, ej_valid=0, ej_data=0, inj_starve=0.
REQ-028 Reset mid-operation SHALL discard queued flits; first accept possible on the first edge after rst_n rises.

Configuration
REQ-029 Macro MESH_INJECTOR_STARVE_EN defined: an 8-bit saturating counter SHALL count consecutive cycles the FIFO is non-empty without a pop; inj_starve SHALL be 1 when counter >= STARVE_LIM; counter and flag clear on the cycle after a pop or when empty.
REQ-030 Macro not defined: no counter, inj_starve SHALL be constant 0.

Verification
REQ-031 Reset, push dst 6'b100_110, all channels idle -> 2 cycles later out_valid=4'b0001, out_dir[0]=00001, rr_ptr=1.
REQ-032 Push dst 6'b100_100 with in_valid=4'b1111 -> next cycle after FIFO write ej_valid=1, out_valid=1111 passthrough, no channel injection.
REQ-033 Push 5 flits back-to-back, in_valid=4'b1111 held, DEPTH=4 -> inj_ready low after 4th accept, 5th waits; release in_valid -> pops resume one per cycle.
REQ-034 Three flits, dst 6'b000_100, in_valid=0 -> injected on channels 0,1,2 in order, out_dir=01000 each.
REQ-035 STARVE_EN, STARVE_LIM=8, in_valid=1111 with queued flit -> inj_starve=1 after 8 cycles; clear in_valid -> inj_starve=0 one cycle after pop.
REQ-036 Assert rst_n low with 3 queued flits -> all outputs 0 asynchronously, inj_ready=1 after release, no stale flit emitted.
